// File: rtl/cdb_pkg.sv
// cdb_pkg: shared CDB widths, source enum and queue entry type
package cdb_pkg;
  localparam int CDB_TAG_W = 4;
  localparam int CDB_DATA_W = 32;
  typedef enum logic {SRC_ADD, SRC_MUL} src_e;
  typedef struct packed {
    logic [CDB_TAG_W-1:0] tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU result handshakes (ready/tag/data/stall per source) plus CDB broadcast and ovf_err; master = FU side, slave = arbiter
interface cdb_arbiter_if import cdb_pkg::*; #(
  parameter int TAG_W = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
);
  logic aFUReady;
  logic [TAG_W-1:0] aFUTag;
  logic [DATA_W-1:0] aFUData;
  logic aFUStall;
  logic mFUReady;
  logic [TAG_W-1:0] mFUTag;
  logic [DATA_W-1:0] mFUData;
  logic mFUStall;
  logic [TAG_W-1:0] broad_tag;
  logic [DATA_W-1:0] broad_data;
  logic broad_valid;
  logic ovf_err;
  modport master (
    output aFUReady, aFUTag, aFUData, mFUReady, mFUTag, mFUData,
    input aFUStall, mFUStall, broad_tag, broad_data, broad_valid, ovf_err
  );
  modport slave (
    input aFUReady, aFUTag, aFUData, mFUReady, mFUTag, mFUData,
    output aFUStall, mFUStall, broad_tag, broad_data, broad_valid, ovf_err
  );
endinterface

// File: rtl/cdb_src_queue.sv
// cdb_src_queue: DEPTH-entry FIFO of {tag,data}; ports clk, reset(async low), push, pop, din, head, full, empty, count
module cdb_src_queue import cdb_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int W = CDB_TAG_W + CDB_DATA_W
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  // a push into a full queue is dropped even if the same edge pops
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin merge of adder/multiplier result queues onto the CDB; ports clk, reset(async low), bus (cdb_arbiter_if.slave)
module cdb_arbiter import cdb_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int TAG_W = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input logic clk,
  input logic reset,
  cdb_arbiter_if.slave bus
);
  localparam int W = TAG_W + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [W-1:0] a_head, m_head;
  logic a_full, a_empty, m_full, m_empty;
  logic [CW-1:0] a_count, m_count;
  logic gnt_a, gnt_m;
  src_e last_grant;
  cdb_src_queue #(.DEPTH(DEPTH), .W(W)) a_q (
    .clk(clk), .reset(reset), .push(bus.aFUReady), .pop(gnt_a),
    .din({bus.aFUTag, bus.aFUData}), .head(a_head), .full(a_full),
    .empty(a_empty), .count(a_count)
  );
  cdb_src_queue #(.DEPTH(DEPTH), .W(W)) m_q (
    .clk(clk), .reset(reset), .push(bus.mFUReady), .pop(gnt_m),
    .din({bus.mFUTag, bus.mFUData}), .head(m_head), .full(m_full),
    .empty(m_empty), .count(m_count)
  );
  assign bus.aFUStall = a_full;
  assign bus.mFUStall = m_full;
  // arbitrate on registered occupancy only, so a same-edge push is never bypassed
  assign gnt_a = ~a_empty & (m_empty | last_grant == SRC_MUL);
  assign gnt_m = ~m_empty & (a_empty | last_grant == SRC_ADD);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.broad_valid <= 1'b0;
      bus.broad_tag <= '0;
      bus.broad_data <= '0;
      bus.ovf_err <= 1'b0;
      last_grant <= SRC_MUL;
    end else begin
      bus.broad_valid <= gnt_a | gnt_m;
      if (gnt_a | gnt_m) begin
        {bus.broad_tag, bus.broad_data} <= gnt_a ? a_head : m_head;
        last_grant <= gnt_a ? SRC_ADD : SRC_MUL;
      end
      if ((bus.aFUReady & a_full) | (bus.mFUReady & m_full)) bus.ovf_err <= 1'b1;
    end
  a_count_ok: assert property (@(posedge clk) disable iff (!reset)
    a_count <= CW'(DEPTH) && a_full == (a_count == CW'(DEPTH)));
  m_count_ok: assert property (@(posedge clk) disable iff (!reset)
    m_count <= CW'(DEPTH) && m_full == (m_count == CW'(DEPTH)));
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with an expected-broadcast scoreboard checked by a negedge monitor
module tb_cdb_arbiter;
  import cdb_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  cdb_arbiter_if #(.TAG_W(CDB_TAG_W), .DATA_W(CDB_DATA_W)) bus ();
  cdb_arbiter #(.DEPTH(2), .TAG_W(CDB_TAG_W), .DATA_W(CDB_DATA_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int tests = 0;
  int fails = 0;
  cdb_entry_t exp_q[$];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.aFUReady = 1'b0;
    bus.mFUReady = 1'b0;
  endtask
  task automatic drive_a(input logic [3:0] tag, input logic [31:0] data);
    bus.aFUReady = 1'b1;
    bus.aFUTag = tag;
    bus.aFUData = data;
  endtask
  task automatic drive_m(input logic [3:0] tag, input logic [31:0] data);
    bus.mFUReady = 1'b1;
    bus.mFUTag = tag;
    bus.mFUData = data;
  endtask
  task automatic expect_bc(input logic [3:0] tag, input logic [31:0] data);
    cdb_entry_t e;
    e.tag = tag;
    e.data = data;
    exp_q.push_back(e);
  endtask
  task automatic do_reset();
    idle();
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask
  // Both FUs offer n results each (adder tag i / data A0+i, multiplier tag 8+i / data B0+i),
  // raising ready only while their stall is low; stall after each edge is logged.
  task automatic run_fu(input int n, input int max_cyc, output int cyc,
                        output logic [15:0] a_st, output logic [15:0] m_st);
    int ai = 0;
    int mi = 0;
    logic ar, mr;
    cyc = 0;
    a_st = '0;
    m_st = '0;
    while ((ai < n || mi < n) && cyc < max_cyc) begin
      ar = (ai < n) && !bus.aFUStall;
      mr = (mi < n) && !bus.mFUStall;
      bus.aFUReady = ar;
      bus.aFUTag = 4'(ai);
      bus.aFUData = 32'('hA0 + ai);
      bus.mFUReady = mr;
      bus.mFUTag = 4'(8 + mi);
      bus.mFUData = 32'('hB0 + mi);
      tick();
      if (ar) ai++;
      if (mr) mi++;
      cyc++;
      a_st[cyc] = bus.aFUStall;
      m_st[cyc] = bus.mFUStall;
    end
    idle();
  endtask
  initial begin
    cdb_entry_t e;
    forever begin
      @(negedge clk);
      if (reset && bus.broad_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_bcast: got tag %0h data %0h, required no broadcast", bus.broad_tag, bus.broad_data);
        end else begin
          e = exp_q.pop_front();
          check("bcast_tag", 64'(bus.broad_tag), 64'(e.tag));
          check("bcast_data", 64'(bus.broad_data), 64'(e.data));
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int cyc;
    logic [15:0] as, ms;
    idle();
    bus.aFUTag = '0;
    bus.aFUData = '0;
    bus.mFUTag = '0;
    bus.mFUData = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.broad_valid), 64'd0);
    check("rst_tag", 64'(bus.broad_tag), 64'd0);
    check("rst_data", 64'(bus.broad_data), 64'd0);
    check("rst_astall", 64'(bus.aFUStall), 64'd0);
    check("rst_mstall", 64'(bus.mFUStall), 64'd0);
    check("rst_ovf", 64'(bus.ovf_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    // single adder push: broadcast after the second edge, gone after the third
    expect_bc(4'd3, 32'h11);
    drive_a(4'd3, 32'h11);
    tick();
    idle();
    check("single_valid_e1", 64'(bus.broad_valid), 64'd0);
    tick();
    check("single_valid_e2", 64'(bus.broad_valid), 64'd1);
    tick();
    check("single_valid_e3", 64'(bus.broad_valid), 64'd0);
    // simultaneous first pushes: adder wins the first tie
    do_reset();
    expect_bc(4'd1, 32'hA);
    expect_bc(4'd9, 32'hB);
    drive_a(4'd1, 32'hA);
    drive_m(4'd9, 32'hB);
    tick();
    idle();
    repeat (3) tick();
    check("tie_valid_done", 64'(bus.broad_valid), 64'd0);
    check("tie_drained", 64'(exp_q.size()), 64'd0);
    // continuous pushes from both FUs respecting stall: strict A/M alternation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      expect_bc(4'(i), 32'('hA0 + i));
      expect_bc(4'(8 + i), 32'('hB0 + i));
    end
    run_fu(5, 20, cyc, as, ms);
    check("stream_cycles", 64'(cyc), 64'd8);
    check("stream_astall_e3", 64'(as[3]), 64'd1);
    check("stream_mstall_e2", 64'(ms[2]), 64'd1);
    check("stream_ovf", 64'(bus.ovf_err), 64'd0);
    repeat (4) tick();
    check("stream_drained", 64'(exp_q.size()), 64'd0);
    // multiplier ignores stall on its third push: dropped, ovf_err sticks
    do_reset();
    expect_bc(4'd2, 32'h20);
    expect_bc(4'd5, 32'h50);
    expect_bc(4'd6, 32'h60);
    drive_a(4'd2, 32'h20);
    drive_m(4'd5, 32'h50);
    tick();
    bus.aFUReady = 1'b0;
    drive_m(4'd6, 32'h60);
    tick();
    check("ovf_mstall_e2", 64'(bus.mFUStall), 64'd1);
    check("ovf_before", 64'(bus.ovf_err), 64'd0);
    drive_m(4'd7, 32'h70);
    tick();
    idle();
    check("ovf_set", 64'(bus.ovf_err), 64'd1);
    repeat (4) tick();
    check("ovf_drained", 64'(exp_q.size()), 64'd0);
    check("ovf_sticky", 64'(bus.ovf_err), 64'd1);
    // reset mid-operation with queued results: nothing queued may survive.
    // Both queues cannot be full at once because one of them pops every cycle,
    // so this uses the fullest reachable state (adder 1, multiplier full).
    drive_a(4'hC, 32'hC0);
    drive_m(4'hD, 32'hD0);
    tick();
    drive_a(4'hE, 32'hE0);
    drive_m(4'hF, 32'hF0);
    tick();
    idle();
    check("mid_pre_mstall", 64'(bus.mFUStall), 64'd1);
    check("mid_pre_valid", 64'(bus.broad_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.broad_valid), 64'd0);
    check("mid_rst_tag", 64'(bus.broad_tag), 64'd0);
    check("mid_rst_data", 64'(bus.broad_data), 64'd0);
    check("mid_rst_mstall", 64'(bus.mFUStall), 64'd0);
    check("mid_rst_astall", 64'(bus.aFUStall), 64'd0);
    check("mid_rst_ovf", 64'(bus.ovf_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) tick();
    check("mid_post_valid", 64'(bus.broad_valid), 64'd0);
    expect_bc(4'd4, 32'h44);
    drive_a(4'd4, 32'h44);
    tick();
    idle();
    repeat (2) tick();
    check("mid_new_drained", 64'(exp_q.size()), 64'd0);
    // multiplier full and popping while its FU re-offers on the stall-release cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      expect_bc(4'(i), 32'('hA0 + i));
      expect_bc(4'(8 + i), 32'('hB0 + i));
    end
    run_fu(3, 20, cyc, as, ms);
    check("refill_cycles", 64'(cyc), 64'd4);
    check("refill_mstall_e2", 64'(ms[2]), 64'd1);
    check("refill_mstall_e3", 64'(ms[3]), 64'd0);
    check("refill_mstall_e4", 64'(ms[4]), 64'd1);
    check("refill_ovf", 64'(bus.ovf_err), 64'd0);
    repeat (5) tick();
    check("refill_drained", 64'(exp_q.size()), 64'd0);
    check("final_valid", 64'(bus.broad_valid), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
